aes_subbytes_seq: RTL and testbench
===================================

// Module: aes_subbytes_seq
// PURPOSE
//  Serialised AES SubBytes/InvSubBytes stage. Feeds aes_shiftrows in the round datapath.
//  Substitutes SBOX_PER_CYCLE bytes per clock, so a 128-bit state takes 16/SBOX_PER_CYCLE cycles.
//  Valid/ready handshake on both sides.
//  The direction flag travels with the data, so the downstream shift stage uses the matching inverse.
// PARAMETERS
//  SBOX_PER_CYCLE  4  S-box lookups per cycle; legal values 1,2,4,8,16; others fail elaboration
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    upstream state valid
//  in_ready     out  1    stage can accept a state
//  in_data      in   128  state; byte k = bits [127-8k -: 8], column-major (byte 0 = row0/col0)
//  in_inverse   in   1    1 = InvSubBytes, 0 = SubBytes; sampled with in_data
//  out_valid    out  1    substituted state available
//  out_ready    in   1    downstream accepts
//  out_data     out  128  substituted state, same byte layout as in_data
//  out_inverse  out  1    direction flag captured with the state
//  busy         out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset (async on rst_n=0): state=IDLE, cnt=0, data reg=0.
//    Outputs: in_ready=1, out_valid=0, out_data=0, out_inverse=0, busy=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid, capture in_data and in_inverse, set cnt=0, go to RUN.
//  - RUN: in_ready=0.
//    - Each cycle, replace bytes [cnt*N .. cnt*N+N-1] with S(b) or S^-1(b), where N=SBOX_PER_CYCLE.
//    - cnt increments. When the last chunk (cnt=16/N-1) is written, go to DONE.
//  - DONE: out_valid=1. out_data and out_inverse hold stable until the out_ready handshake, then go to IDLE.
//  - Latency: in handshake at edge E -> out_valid high after edge E+16/N (E+4 at default).
//    No accept in the DONE->IDLE cycle. Throughput: one state per 16/N+2 cycles.
//  - in_ready depends only on state, never combinationally on out_ready; no in->out combinational path.
//  - in_valid high while busy is ignored. Upstream must hold in_data until in_ready.
//  - cnt width: clog2(16/N), minimum 1 bit. Counter wrap is never used; exit to DONE is explicit.
//  - Reset mid-RUN or mid-DONE: abandons the block immediately. No out_valid is emitted for it.
//  - S-box values exactly per FIPS-197, in both directions.
// CONFIGURATION
//  - AES_SUBBYTES_CLEAR_EN defined: on the out handshake in DONE, the data register and out_inverse
//    are cleared to 0 in the same edge (masking of leftover state for power analysis).
//    out_data reads 0 while in IDLE.
//  - Undefined: the data register keeps the last result until the next capture.
//    out_data is only meaningful while out_valid=1.
// STRUCTURE
//  - aes_pkg: AES_STATE_W=128, AES_BYTE_W=8, FSM state encodings (IDLE/RUN/DONE), legal SBOX_PER_CYCLE check.
//  - Sub-module aes_sbox: combinational 8-bit byte in + inverse flag -> byte out.
//    SBOX_PER_CYCLE instances are generated. The same module is reused by the key schedule.
// TESTING
//  1. in_data=00102030405060708090a0b0c0d0e0f0, inverse=0
//     -> out_data=63cab7040953d051cd60e0e7ba70e18c with out_valid 4 cycles after accept.
//  2. in_data=63cab7040953d051cd60e0e7ba70e18c, inverse=1
//     -> out_data=00102030405060708090a0b0c0d0e0f0, out_inverse=1.
//  3. All-00 input, out_ready held low 10 cycles -> out_data=6363..63 stable, out_valid=1, in_ready=0.
//     In-flight in_valid pulses are ignored.
//  4. rst_n pulsed low at RUN cycle 2 -> all outputs at reset values immediately; no out_valid afterwards.
//     The next block processes correctly.
//  5. SBOX_PER_CYCLE=1 and =16, all-FF input -> out_data=1616..16 with latency 16 and 1 respectively.
//  6. With AES_SUBBYTES_CLEAR_EN: out_data=0 in the cycle after the handshake.
//     Without it: the value is retained.

Source files
------------

// File: rtl/aes_pkg.sv
// +------------------------------------------------------------------+
// | aes_pkg: shared AES widths, stage FSM encoding, GF(2^8) helpers  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_t;

    function automatic bit sbox_per_cycle_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// +------------------------------------------------------------------+
// | aes_sbox: combinational AES S-box / inverse S-box, one byte      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_in,
    input  logic                  inverse,
    output logic [AES_BYTE_W-1:0] byte_out
);

    logic [7:0] w_inv_affine;
    logic [7:0] w_gf_in;
    logic [7:0] w_gf_out;
    logic [7:0] w_fwd_affine;

    // One shared field inverter: inverse path undoes the affine map first.
    assign w_inv_affine = {byte_in[6:0], byte_in[7]}   ^ {byte_in[4:0], byte_in[7:5]}
                        ^ {byte_in[1:0], byte_in[7:2]} ^ 8'h05;
    assign w_gf_in      = inverse ? w_inv_affine : byte_in;
    assign w_gf_out     = gf_inv(w_gf_in);
    assign w_fwd_affine = w_gf_out ^ {w_gf_out[6:0], w_gf_out[7]} ^ {w_gf_out[5:0], w_gf_out[7:6]}
                        ^ {w_gf_out[4:0], w_gf_out[7:5]} ^ {w_gf_out[3:0], w_gf_out[7:4]} ^ 8'h63;
    assign byte_out     = inverse ? w_gf_out : w_fwd_affine;

endmodule

`default_nettype wire

// File: rtl/aes_subbytes_seq.sv
// +------------------------------------------------------------------+
// | aes_subbytes_seq: serialised SubBytes/InvSubBytes, valid/ready   |
// | Option macro AES_SUBBYTES_CLEAR_EN clears data after handoff.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_inverse,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   out_inverse,
    output logic                   busy
);

    localparam int CHUNKS  = 16 / SBOX_PER_CYCLE;
    localparam int CHUNK_W = SBOX_PER_CYCLE * AES_BYTE_W;
    localparam int CNT_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(CHUNKS - 1);
    localparam logic [AES_STATE_W-1:0] CHUNK_MASK = ~({AES_STATE_W{1'b1}} >> CHUNK_W);

    generate
        if (!sbox_per_cycle_legal(SBOX_PER_CYCLE)) begin : g_bad_sbox_per_cycle
            $error("aes_subbytes_seq: SBOX_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sub_state_t             r_state;
    sub_state_t             w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [AES_STATE_W-1:0] r_data;
    logic                   r_inverse;

    logic [7:0]             w_shamt;
    logic [AES_STATE_W-1:0] w_shifted;
    logic [CHUNK_W-1:0]     w_chunk_in;
    logic [CHUNK_W-1:0]     w_chunk_out;
    logic [AES_STATE_W-1:0] w_out_wide;
    logic [AES_STATE_W-1:0] w_data_next;

    // Chunk cnt starts at byte cnt*N, i.e. bit offset cnt*CHUNK_W from the MSB.
    assign w_shamt     = 8'(r_cnt) * 8'(CHUNK_W);
    assign w_shifted   = r_data << w_shamt;
    assign w_chunk_in  = CHUNK_W'(w_shifted >> (AES_STATE_W - CHUNK_W));
    assign w_out_wide  = AES_STATE_W'(w_chunk_out) << (AES_STATE_W - CHUNK_W);
    assign w_data_next = (r_data & ~(CHUNK_MASK >> w_shamt)) | (w_out_wide >> w_shamt);

    generate
        for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_sbox
            aes_sbox u_sbox (
                .byte_in  (w_chunk_in [CHUNK_W-1-AES_BYTE_W*j -: AES_BYTE_W]),
                .inverse  (r_inverse),
                .byte_out (w_chunk_out[CHUNK_W-1-AES_BYTE_W*j -: AES_BYTE_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)           w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST)  w_state_next = ST_DONE;
            ST_DONE: if (out_ready)          w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_inverse <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data    <= in_data;
                        r_inverse <= in_inverse;
                        r_cnt     <= '0;
                    end
                end
                ST_RUN: begin
                    r_data <= w_data_next;
                    if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
                end
`ifdef AES_SUBBYTES_CLEAR_EN
                ST_DONE: begin
                    // Scrub the finished state so it does not linger after handoff.
                    if (out_ready) begin
                        r_data    <= '0;
                        r_inverse <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign out_data    = r_data;
    assign out_inverse = r_inverse;

endmodule

`default_nettype wire

// File: tb/tb_aes_subbytes_seq.sv
// +------------------------------------------------------------------+
// | tb_aes_subbytes_seq: scoreboard bench for aes_subbytes_seq        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_aes_subbytes_seq;

    localparam logic [127:0] VEC_PT = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] VEC_SB = 128'h63cab7040953d051cd60e0e7ba70e18c;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_inverse;
    logic         out_valid, out_ready, out_inverse, busy;
    logic [127:0] in_data, out_data;

    logic         v_valid, v_oready;
    logic [127:0] v_data;
    logic         v1_ready, v1_ovalid, v1_oinv, v1_busy;
    logic [127:0] v1_odata;
    logic         v16_ready, v16_ovalid, v16_oinv, v16_busy;
    logic [127:0] v16_odata;

    always #5 clk = ~clk;

    aes_subbytes_seq #(.SBOX_PER_CYCLE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inverse(in_inverse),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inverse(out_inverse), .busy(busy)
    );

    aes_subbytes_seq #(.SBOX_PER_CYCLE(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v_valid), .in_ready(v1_ready), .in_data(v_data), .in_inverse(1'b0),
        .out_valid(v1_ovalid), .out_ready(v_oready), .out_data(v1_odata),
        .out_inverse(v1_oinv), .busy(v1_busy)
    );

    aes_subbytes_seq #(.SBOX_PER_CYCLE(16)) dut_n16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v_valid), .in_ready(v16_ready), .in_data(v_data), .in_inverse(1'b0),
        .out_valid(v16_ovalid), .out_ready(v_oready), .out_data(v16_odata),
        .out_inverse(v16_oinv), .busy(v16_busy)
    );

    typedef struct {
        logic [127:0] data;
        logic         inv;
        int           acc_cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] sb  [0:255];
    logic [7:0] isb [0:255];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference tables from the generator walk (p*3 / q/3), independent of x^254.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[127-8*k -: 8] = inv ? isb[d[127-8*k -: 8]] : sb[d[127-8*k -: 8]];
        return r;
    endfunction

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp_d);
        bit   accepted = 0;
        logic rdy;
        exp_t e;
        in_data    = d;
        in_inverse = inv;
        in_valid   = 1'b1;
        for (int t = 0; t < 100 && !accepted; t++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) accepted = 1;
        end
        in_valid = 1'b0;
        if (accepted) begin
            e.data = exp_d; e.inv = inv; e.acc_cyc = cyc;
            sbq.push_back(e);
        end else begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready never seen high");
        end
    endtask

    task automatic recv(input int max_wait, input bit chk_lat, input int exp_lat);
        bit   got = 0;
        exp_t e;
        out_ready = 1'b1;
        for (int t = 0; t < max_wait && !got; t++) begin
            if (out_valid) begin
                got = 1;
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: out_data=%h with empty scoreboard", out_data);
                end else begin
                    e = sbq.pop_front();
                    n_cmp++;
                    if (out_data !== e.data) begin
                        n_err++;
                        $display("FAIL out_data: got %h expected %h", out_data, e.data);
                    end
                    n_cmp++;
                    if (out_inverse !== e.inv) begin
                        n_err++;
                        $display("FAIL out_inverse: got %b expected %b", out_inverse, e.inv);
                    end
                    if (chk_lat) begin
                        n_cmp++;
                        if (cyc - e.acc_cyc !== exp_lat) begin
                            n_err++;
                            $display("FAIL latency: got %0d expected %0d", cyc - e.acc_cyc, exp_lat);
                        end
                    end
                end
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL recv_timeout: out_valid not seen within %0d cycles", max_wait);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0)     begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_cmp++; if (out_inverse !== 1'b0) begin n_err++; $display("FAIL reset_out_inverse: got %b expected 0", out_inverse); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        send(VEC_PT, 1'b0, VEC_SB);
        recv(20, 1, 4);
        send(VEC_SB, 1'b1, VEC_PT);
        recv(20, 1, 4);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d[6];
        logic         iv[6];
        for (int i = 0; i < 6; i++) begin
            d[i]  = {$urandom, $urandom, $urandom, $urandom};
            iv[i] = 1'($urandom_range(0, 1));
        end
        fork
            begin
                for (int i = 0; i < 6; i++) send(d[i], iv[i], model(d[i], iv[i]));
            end
            begin
                for (int i = 0; i < 6; i++) recv(40, 1, 4);
            end
        join
    endtask

    task automatic test_stall();
        bit seen = 0;
        out_ready = 1'b0;
        send('0, 1'b0, {16{8'h63}});
        for (int t = 0; t < 20 && !seen; t++) begin
            if (out_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL stall_valid_timeout: out_valid not seen"); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
            n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL stall_busy: got %b expected 1", busy); end
            n_cmp++; if (out_data !== {16{8'h63}}) begin n_err++; $display("FAIL stall_out_data: got %h expected %h", out_data, {16{8'h63}}); end
            in_valid = (i % 2 == 0);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        recv(5, 0, 0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_extra_output: out_valid got %b expected 0", out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_run();
        bit spurious = 0;
        out_ready = 1'b1;
        send(VEC_PT, 1'b1, model(VEC_PT, 1'b1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0)      begin n_err++; $display("FAIL midrst_out_data: got %h expected 0", out_data); end
        n_cmp++; if (out_inverse !== 1'b0) begin n_err++; $display("FAIL midrst_out_inverse: got %b expected 0", out_inverse); end
        n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) spurious = 1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (spurious) begin n_err++; $display("FAIL midrst_abandoned: out_valid got 1 expected 0"); end
        send(VEC_PT, 1'b0, VEC_SB);
        recv(20, 1, 4);
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        send(VEC_SB, 1'b1, VEC_PT);
        recv(20, 1, 4);
`ifdef AES_SUBBYTES_CLEAR_EN
        n_cmp++; if (out_data !== '0)      begin n_err++; $display("FAIL post_handoff_data: got %h expected 0", out_data); end
        n_cmp++; if (out_inverse !== 1'b0) begin n_err++; $display("FAIL post_handoff_inverse: got %b expected 0", out_inverse); end
`else
        n_cmp++; if (out_data !== VEC_PT)  begin n_err++; $display("FAIL post_handoff_data: got %h expected %h", out_data, VEC_PT); end
        n_cmp++; if (out_inverse !== 1'b1) begin n_err++; $display("FAIL post_handoff_inverse: got %b expected 1", out_inverse); end
`endif
    endtask

    task automatic test_param_variants();
        int           lat1 = -1, lat16 = -1;
        logic [127:0] d1 = '0, d16 = '0;
        int           acc;
        v_oready = 1'b1;
        v_data   = {16{8'hff}};
        v_valid  = 1'b1;
        @(posedge clk); #1;
        v_valid = 1'b0;
        acc = cyc;
        for (int t = 0; t < 40; t++) begin
            if (v1_ovalid && lat1 < 0)   begin lat1 = cyc - acc;  d1 = v1_odata;  end
            if (v16_ovalid && lat16 < 0) begin lat16 = cyc - acc; d16 = v16_odata; end
            @(posedge clk); #1;
        end
        n_cmp++; if (lat1 !== 16)            begin n_err++; $display("FAIL n1_latency: got %0d expected 16", lat1); end
        n_cmp++; if (d1 !== {16{8'h16}})     begin n_err++; $display("FAIL n1_out_data: got %h expected %h", d1, {16{8'h16}}); end
        n_cmp++; if (lat16 !== 1)            begin n_err++; $display("FAIL n16_latency: got %0d expected 1", lat16); end
        n_cmp++; if (d16 !== {16{8'h16}})    begin n_err++; $display("FAIL n16_out_data: got %h expected %h", d16, {16{8'h16}}); end
    endtask

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        v_valid    = 1'b0;
        v_data     = '0;
        v_oready   = 1'b1;
        build_tables();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_mid_run();
        test_clear();
        test_param_variants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
